quant_coeff_loader: RTL

- Sequences software-initiated writes into the quantizer's per-channel gain/coefficient BRAM.
- Source values are PPC-written OPB software registers: address, data and control.
- Supports single-word writes and bulk fills of a channel range.
- Writes can optionally be held until the next spectrum sync, so gains change on a spectrum boundary; status is exported for a readback register.

---
 rtl/quant_coeff_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/quant_coeff_loader.sv
// Sequences software-requested writes into the quantizer coefficient BRAM.
// Supports single words, wrapping range fills and spectrum-sync gating.
module quant_coeff_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              OPB_Clk,
  input  logic              OPB_Rst,
  input  logic [31:0]       reg_addr,
  input  logic [31:0]       reg_data,
  input  logic [31:0]       reg_ctrl,
  input  logic              sync_in,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [DATA_W-1:0] coef_din,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status
);

  // Wide enough to hold both the largest length field and a full 2^ADDR_W fill.
  localparam int REM_W = ((LEN_W > ADDR_W) ? LEN_W : ADDR_W) + 1;

  typedef enum logic [1:0] {IDLE, ARM, WRITE, DONE} state_t;

  state_t            state;
  logic              ctrl0_d;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [REM_W-1:0]  remaining;
  logic [REM_W-1:0]  fill_len;
  logic [15:0]       count;
  logic [15:0]       last_count;
  logic              overrun;
  logic              aborted;
  logic              go;
  logic              abort;

  assign abort = reg_ctrl[3];
  assign go    = reg_ctrl[0] & ~ctrl0_d & ~abort;
  assign busy  = (state == ARM) || (state == WRITE);
  assign status = {13'b0, busy, aborted, overrun, last_count};

  always_comb begin
    fill_len = REM_W'(1);
    if (reg_ctrl[2]) begin
      if (reg_ctrl[16 +: LEN_W] == '0)
        fill_len = REM_W'(1) << ADDR_W;
      else
        fill_len = REM_W'(reg_ctrl[16 +: LEN_W]);
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state      <= IDLE;
      ctrl0_d    <= 1'b0;
      addr       <= '0;
      data       <= '0;
      remaining  <= '0;
      count      <= '0;
      last_count <= '0;
      overrun    <= 1'b0;
      aborted    <= 1'b0;
      coef_we    <= 1'b0;
      coef_addr  <= '0;
      coef_din   <= '0;
      done       <= 1'b0;
    end else begin
      ctrl0_d <= reg_ctrl[0];
      coef_we <= 1'b0;
      done    <= 1'b0;

      if (abort)
        overrun <= 1'b0;
      else if (go && state != IDLE)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (go) begin
            addr      <= reg_addr[ADDR_W-1:0];
            data      <= reg_data[DATA_W-1:0];
            remaining <= fill_len;
            count     <= '0;
            aborted   <= 1'b0;
            state     <= reg_ctrl[1] ? ARM : WRITE;
          end
        end
        ARM: begin
          if (abort) begin
            aborted    <= 1'b1;
            last_count <= count;
            state      <= IDLE;
          end else if (sync_in) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            aborted    <= 1'b1;
            last_count <= count;
            state      <= IDLE;
          end else begin
            coef_we   <= 1'b1;
            coef_addr <= addr;
            coef_din  <= data;
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (count != 16'hFFFF)
              count <= count + 16'd1;
            if (remaining == REM_W'(1))
              state <= DONE;
          end
        end
        DONE: begin
          // The final word is already on the bus; an abort here only suppresses done.
          last_count <= count;
          state      <= IDLE;
          if (abort)
            aborted <= 1'b1;
          else
            done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
